// File: rtl/cdm_seq_mult.sv
// Purpose: sequential WIDTH x WIDTH unsigned multiplier, one 4-bit slice of b per cycle,
//          with per-transaction exact or carry-disregard (approximate) slice reduction.
// Latency: out_valid rises WIDTH/4 edges after the accept edge; one result per WIDTH/4+2 cycles min.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b, approx sampled on the accept edge
//   out_valid/out_ready result handshake; r holds the last product until the next completion
//   busy                high while a transaction is in BUSY or DONE
module cdm_seq_mult #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r,
  output logic               busy
);

  localparam int NS   = WIDTH / 4;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
  localparam int SPW  = WIDTH + 4;   // a * 15 always fits
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              approx_q;
  logic [PW-1:0]     acc_q, acc_next;
  logic [IDXW-1:0]   idx_q;
  logic [PW-1:0]     r_q;

  logic [IDXW+1:0]   shamt;
  logic [3:0]        b_slc;
  logic [SPW-1:0]    row [4];
  logic [SPW-1:0]    low_mask;
  logic [SPW-1:0]    sum_exact, or_low, sum_high, sp;
  logic              last_slice;

  assign shamt      = {idx_q, 2'b00};
  assign last_slice = (idx_q == IDXW'(NS - 1));

  // Slice partial product. In approximate mode the low APPROX_COLS columns are
  // collapsed with OR, so no carry from them reaches column APPROX_COLS.
  always_comb begin
    b_slc    = 4'(b_q >> shamt);
    low_mask = '0;
    for (int i = 0; i < SPW; i++) begin
      low_mask[i] = (i < APPROX_COLS);
    end
    sum_exact = '0;
    or_low    = '0;
    sum_high  = '0;
    for (int j = 0; j < 4; j++) begin
      row[j]    = b_slc[j] ? (SPW'(a_q) << j) : '0;
      sum_exact = sum_exact + row[j];
      or_low    = or_low | (row[j] & low_mask);
      sum_high  = sum_high + (row[j] & ~low_mask);
    end
    sp       = approx_q ? (or_low + sum_high) : sum_exact;
    // Bits shifted past the top are dropped: accumulation is mod 2^(2*WIDTH).
    acc_next = acc_q + (PW'(sp) << shamt);
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      r_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            approx_q <= approx;
            acc_q    <= '0;
            idx_q    <= '0;
          end
        end
        BUSY: begin
          acc_q <= acc_next;
          idx_q <= idx_q + IDXW'(1);
          if (last_slice) r_q <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign r = r_q;

endmodule

// File: tb/tb_cdm_seq_mult.sv
module tb_cdm_seq_mult;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // WIDTH=8, APPROX_COLS=4 instance
  logic        in_valid, in_ready, approx, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] r;

  cdm_seq_mult #(.WIDTH(8), .APPROX_COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx(approx), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .busy(busy)
  );

  // WIDTH=16, APPROX_COLS=0 instance
  logic        h_in_valid, h_in_ready, h_approx, h_out_valid, h_out_ready, h_busy;
  logic [15:0] h_a, h_b;
  logic [31:0] h_r;

  cdm_seq_mult #(.WIDTH(16), .APPROX_COLS(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .approx(h_approx), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .r(h_r), .busy(h_busy)
  );

  // WIDTH=4, APPROX_COLS=0 instance
  logic        q_in_valid, q_in_ready, q_approx, q_out_valid, q_out_ready, q_busy;
  logic [3:0]  q_a, q_b;
  logic [7:0]  q_r;

  cdm_seq_mult #(.WIDTH(4), .APPROX_COLS(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .a(q_a), .b(q_b), .approx(q_approx), .out_valid(q_out_valid), .out_ready(q_out_ready),
    .r(q_r), .busy(q_busy)
  );

  // Handshake monitors on the 8-bit instance
  int acc_cnt = 0;
  int hs_cnt  = 0;
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_cnt++;
    if (rst_n && out_valid && out_ready) hs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model, WIDTH=8, APPROX_COLS=4
  function automatic logic [15:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic map);
    logic [15:0] acc;
    logic [11:0] rw, ex, orl, hi, sp;
    acc = '0;
    for (int k = 0; k < 2; k++) begin
      ex = '0; orl = '0; hi = '0;
      for (int j = 0; j < 4; j++) begin
        rw  = mb[4*k+j] ? ({4'b0, ma} << j) : 12'h000;
        ex  = ex + rw;
        orl = orl | (rw & 12'h00F);
        hi  = hi + (rw & 12'hFF0);
      end
      sp  = map ? (orl + hi) : ex;
      acc = acc + (16'(sp) << (4*k));
    end
    return acc;
  endfunction

  // Present operands for one accept edge on the 8-bit instance.
  task automatic start8(input logic [7:0] ta, input logic [7:0] tb, input logic tap);
    a = ta; b = tb; approx = tap; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait8(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release8();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (r !== 16'd0) begin miscompares++; $display("FAIL reset_r got %0d want 0", r); end
  endtask

  task automatic test_exact_max();
    int lat;
    start8(8'hFF, 8'hFF, 1'b0);
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL max_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait8(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL max_latency got %0d want 2", lat); end
    vectors++; if (r !== 16'd65025) begin miscompares++; $display("FAIL max_r got %0d want 65025", r); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || r !== 16'd65025 || in_ready !== 1'b0)
      begin miscompares++; $display("FAIL max_hold cycle %0d got ov=%b r=%0d ir=%b want 1/65025/0", i, out_valid, r, in_ready); end
    end
    release8();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
    begin miscompares++; $display("FAIL max_release got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    tick(); tick();
    vectors++; if (r !== 16'd65025) begin miscompares++; $display("FAIL idle_hold_r got %0d want 65025", r); end
  endtask

  task automatic test_approx();
    logic [7:0]  ta [5] = '{8'h0F, 8'hFF, 8'hFF, 8'h0F, 8'h00};
    logic [7:0]  tb [5] = '{8'h03, 8'hFF, 8'h11, 8'h03, 8'hFF};
    logic        tp [5] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [15:0] te [5] = '{16'd31, 16'hFBBF, 16'd4335, 16'd45, 16'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start8(ta[i], tb[i], tp[i]);
      wait8(lat);
      vectors++;
      if (!out_valid || lat != 2 || r !== te[i])
      begin miscompares++; $display("FAIL approx_vec%0d got r=%0d lat=%0d want r=%0d lat=2", i, r, lat, te[i]); end
      release8();
    end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    a = 8'd3; b = 8'd5; approx = 1'b0; in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = a + 8'd17; b = b + 8'd29; approx = ~approx;
      tick();
      lat++;
    end
    a = 8'hAA; b = 8'h55; tick();
    vectors++; if (out_valid !== 1'b1 || r !== 16'd15 || in_ready !== 1'b0)
    begin miscompares++; $display("FAIL ignore_inputs got ov=%b r=%0d ir=%b want 1/15/0", out_valid, r, in_ready); end
    in_valid = 1'b0;
    release8();
  endtask

  task automatic test_reset_mid();
    int lat;
    start8(8'h77, 8'h99, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || r !== 16'd0)
    begin miscompares++; $display("FAIL mid_reset got ir=%b ov=%b busy=%b r=%0d want 1/0/0/0", in_ready, out_valid, busy, r); end
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_no_pulse got ov=%b want 0", out_valid); end
    rst_n = 1'b1;
    tick();
    start8(8'h0F, 8'h03, 1'b0);
    wait8(lat);
    vectors++; if (!out_valid || r !== 16'd45)
    begin miscompares++; $display("FAIL post_reset_txn got ov=%b r=%0d want 1/45", out_valid, r); end
    release8();
  endtask

  task automatic test_w16();
    logic [15:0] xa, xb;
    int lat;
    for (int i = 0; i < 300; i++) begin
      xa = (i == 0) ? 16'hFFFF : 16'($urandom);
      xb = (i == 0) ? 16'hFFFF : 16'($urandom);
      h_a = xa; h_b = xb; h_approx = i[0]; h_in_valid = 1'b1;
      tick();
      h_in_valid = 1'b0;
      lat = 0;
      while (!h_out_valid && lat < 20) begin tick(); lat++; end
      vectors++;
      if (!h_out_valid || lat != 4 || h_r !== 32'(xa) * 32'(xb))
      begin miscompares++; $display("FAIL w16 %0d*%0d ap=%0d got r=%0d lat=%0d want r=%0d lat=4", xa, xb, i[0], h_r, lat, 32'(xa) * 32'(xb)); end
      h_out_ready = 1'b1; tick(); h_out_ready = 1'b0;
    end
  endtask

  task automatic test_w4();
    logic [3:0] xa, xb;
    int lat;
    for (int i = 0; i < 300; i++) begin
      xa = (i == 0) ? 4'hF : 4'($urandom);
      xb = (i == 0) ? 4'hF : 4'($urandom);
      q_a = xa; q_b = xb; q_approx = i[0]; q_in_valid = 1'b1;
      tick();
      q_in_valid = 1'b0;
      lat = 0;
      while (!q_out_valid && lat < 20) begin tick(); lat++; end
      vectors++;
      if (!q_out_valid || lat != 1 || q_r !== 8'(xa) * 8'(xb))
      begin miscompares++; $display("FAIL w4 %0d*%0d ap=%0d got r=%0d lat=%0d want r=%0d lat=1", xa, xb, i[0], q_r, lat, 8'(xa) * 8'(xb)); end
      q_out_ready = 1'b1; tick(); q_out_ready = 1'b0;
    end
  endtask

  task automatic test_random_stall();
    int n = 2000;
    int acc0, hs0, lat, guard;
    logic [7:0]  xa, xb;
    logic [15:0] exp;
    logic        o;
    acc0 = acc_cnt; hs0 = hs_cnt;
    for (int t = 0; t < n; t++) begin
      xa = 8'($urandom); xb = 8'($urandom);
      exp = model8(xa, xb, 1'b1);
      // idle gaps with in_valid low and out_ready toggling
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        in_valid = 1'b0; out_ready = 1'($urandom); a = 8'($urandom); tick();
      end
      out_ready = 1'b0;
      a = xa; b = xb; approx = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      wait8(lat);
      in_valid = 1'b0;
      vectors++;
      if (!out_valid || r !== exp)
      begin miscompares++; $display("FAIL stall_txn%0d %0d*%0d got ov=%b r=%0d want r=%0d", t, xa, xb, out_valid, r, exp); end
      guard = 0;
      do begin
        o = 1'($urandom);
        out_ready = o;
        tick();
        guard++;
      end while (!o && guard < 30);
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin miscompares++; $display("FAIL stall_release%0d got ov=%b ir=%b want 0/1", t, out_valid, in_ready); end
    end
    vectors++;
    if (acc_cnt - acc0 != n || hs_cnt - hs0 != n)
    begin miscompares++; $display("FAIL stall_counts got accepts=%0d results=%0d want %0d", acc_cnt - acc0, hs_cnt - hs0, n); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; approx = 1'b0; out_ready = 1'b0;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_approx = 1'b0; h_out_ready = 1'b0;
    q_in_valid = 1'b0; q_a = '0; q_b = '0; q_approx = 1'b0; q_out_ready = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_exact_max();
    test_approx();
    test_ignore_inputs();
    test_reset_mid();
    test_w16();
    test_w4();
    test_random_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
